// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_if
//  Description : Decode-stage instruction, data-memory handshake and all
//                pipeline control outputs of pipe_ctrl, bundled as one port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
    logic [31:0] instrD;
    logic        dmem_ready;
    logic        LoadD;
    logic        ByteD;
    logic        IllegalD;
    logic [2:0]  AluControlE;
    logic        ALUSrcE;
    logic        MemWriteM;
    logic        MemReadM;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic        ByteW;
    logic        StallF;
    logic        StallD;
    logic        StallE;
    logic        StallM;
    logic        FlushE;

    // Driver side: supplies the instruction and memory handshake
    modport master (
        output instrD, dmem_ready,
        input  LoadD, ByteD, IllegalD, AluControlE, ALUSrcE, MemWriteM,
               MemReadM, RegWriteW, MemtoRegW, ByteW, StallF, StallD,
               StallE, StallM, FlushE
    );

    // Controller side
    modport slave (
        input  instrD, dmem_ready,
        output LoadD, ByteD, IllegalD, AluControlE, ALUSrcE, MemWriteM,
               MemReadM, RegWriteW, MemtoRegW, ByteW, StallF, StallD,
               StallE, StallM, FlushE
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Five-stage pipeline controller: decodes the D-stage
//                instruction, carries its controls through E/M/W, detects
//                RAW hazards and freezes the pipe during data-memory waits.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl (
    input  wire logic  clk,
    input  wire logic  reset,
    pipe_ctrl_if.slave bus
);
    localparam logic [6:0] c_OP_R   = 7'b0110011;
    localparam logic [6:0] c_OP_I   = 7'b0010011;
    localparam logic [6:0] c_OP_L   = 7'b0000011;
    localparam logic [6:0] c_OP_S   = 7'b0100011;
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_HAZ     = 2'd1,
        S_MEMWAIT = 2'd2
    } state_t;

    state_t      r_state, w_state_next;

    logic [6:0]  w_op, w_f7;
    logic [2:0]  w_f3;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic        w_use_rs2;

    logic        w_legal, w_d_load, w_d_byte, w_d_alusrc, w_d_memread;
    logic        w_d_memwrite, w_d_memtoreg, w_d_regwrite;
    logic [2:0]  w_d_alu;

    logic        r_e_regwrite, r_e_memtoreg, r_e_memread, r_e_memwrite;
    logic        r_e_byte, r_e_alusrc;
    logic [2:0]  r_e_alu;
    logic [4:0]  r_e_rd;
    logic        r_m_regwrite, r_m_memtoreg, r_m_memread, r_m_memwrite, r_m_byte;
    logic [4:0]  r_m_rd;
    logic        r_w_regwrite, r_w_memtoreg, r_w_byte;
    logic [4:0]  r_w_rd;

    logic        w_raw, w_mem_wait, w_stall_fd, w_stall_em, w_flush_e;

    assign w_op      = bus.instrD[6:0];
    assign w_rd      = bus.instrD[11:7];
    assign w_f3      = bus.instrD[14:12];
    assign w_rs1     = bus.instrD[19:15];
    assign w_rs2     = bus.instrD[24:20];
    assign w_f7      = bus.instrD[31:25];
    assign w_use_rs2 = (w_op == c_OP_R) || (w_op == c_OP_S);

    // An older instruction conflicts when it really writes a register (rd!=0)
    // that the decode-stage instruction reads.
    function automatic logic f_hit(input logic wr, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic use_rs2);
        return wr && (rd != 5'd0) && ((rd == rs1) || (use_rs2 && (rd == rs2)));
    endfunction

    // Instruction decode; unsupported encodings leave every control at its bubble value
    always_comb begin
        w_legal      = 1'b0;
        w_d_load     = 1'b0;
        w_d_byte     = 1'b0;
        w_d_alusrc   = 1'b0;
        w_d_memread  = 1'b0;
        w_d_memwrite = 1'b0;
        w_d_memtoreg = 1'b0;
        w_d_regwrite = 1'b0;
        w_d_alu      = c_ALU_ADD;
        case (w_op)
            c_OP_R: begin
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000:  begin w_legal = 1'b1; w_d_alu = c_ALU_ADD; end
                        3'b111:  begin w_legal = 1'b1; w_d_alu = c_ALU_AND; end
                        3'b110:  begin w_legal = 1'b1; w_d_alu = c_ALU_OR;  end
                        default: ;
                    endcase
                end else if ((w_f7 == 7'b0100000) && (w_f3 == 3'b000)) begin
                    w_legal = 1'b1;
                    w_d_alu = c_ALU_SUB;
                end
                w_d_regwrite = w_legal;
            end
            c_OP_I: begin
                if (w_f3 == 3'b000) begin
                    w_legal      = 1'b1;
                    w_d_load     = 1'b1;
                    w_d_alusrc   = 1'b1;
                    w_d_regwrite = 1'b1;
                end
            end
            c_OP_L: begin
                if ((w_f3 == 3'b010) || (w_f3 == 3'b000)) begin
                    w_legal      = 1'b1;
                    w_d_load     = 1'b1;
                    w_d_alusrc   = 1'b1;
                    w_d_memread  = 1'b1;
                    w_d_memtoreg = 1'b1;
                    w_d_regwrite = 1'b1;
                    w_d_byte     = (w_f3 == 3'b000);
                end
            end
            c_OP_S: begin
                if ((w_f3 == 3'b010) || (w_f3 == 3'b000)) begin
                    w_legal      = 1'b1;
                    w_d_alusrc   = 1'b1;
                    w_d_memwrite = 1'b1;
                    w_d_byte     = (w_f3 == 3'b000);
                end
            end
            default: ;
        endcase
    end

    // RAW hazard against every instruction still ahead of decode, plus memory wait
    always_comb begin
        w_raw = f_hit(r_e_regwrite, r_e_rd, w_rs1, w_rs2, w_use_rs2) ||
                f_hit(r_m_regwrite, r_m_rd, w_rs1, w_rs2, w_use_rs2) ||
                f_hit(r_w_regwrite, r_w_rd, w_rs1, w_rs2, w_use_rs2);
        w_mem_wait = (r_m_memread || r_m_memwrite) && !bus.dmem_ready;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_RUN;
        else        r_state <= w_state_next;
    end

    // FSM next state and stall/flush generation; memory wait outranks hazards
    always_comb begin
        w_state_next = r_state;
        w_stall_fd   = 1'b0;
        w_stall_em   = 1'b0;
        w_flush_e    = 1'b0;
        case (r_state)
            S_MEMWAIT: begin
                if (!bus.dmem_ready) begin
                    w_stall_fd = 1'b1;
                    w_stall_em = 1'b1;
                end else begin
                    // Access done this cycle: hazard is looked at again now
                    w_state_next = S_RUN;
                    w_stall_fd   = w_raw;
                    w_flush_e    = w_raw;
                end
            end
            default: begin
                if (w_mem_wait) begin
                    w_stall_fd   = 1'b1;
                    w_stall_em   = 1'b1;
                    w_state_next = S_MEMWAIT;
                end else if (w_raw) begin
                    w_stall_fd   = 1'b1;
                    w_flush_e    = 1'b1;
                    w_state_next = S_HAZ;
                end else begin
                    w_state_next = S_RUN;
                end
            end
        endcase
    end

    // E stage: load decoded controls, or a bubble on hazard / illegal, hold on memory wait
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || (!w_stall_em && (w_flush_e || !w_legal))) begin
            r_e_regwrite <= 1'b0;
            r_e_memtoreg <= 1'b0;
            r_e_memread  <= 1'b0;
            r_e_memwrite <= 1'b0;
            r_e_byte     <= 1'b0;
            r_e_alusrc   <= 1'b0;
            r_e_alu      <= c_ALU_ADD;
            r_e_rd       <= 5'd0;
        end else if (!w_stall_em) begin
            r_e_regwrite <= w_d_regwrite;
            r_e_memtoreg <= w_d_memtoreg;
            r_e_memread  <= w_d_memread;
            r_e_memwrite <= w_d_memwrite;
            r_e_byte     <= w_d_byte;
            r_e_alusrc   <= w_d_alusrc;
            r_e_alu      <= w_d_alu;
            r_e_rd       <= w_rd;
        end
    end

    // M stage: advance from E unless the memory access is still pending
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m_regwrite <= 1'b0;
            r_m_memtoreg <= 1'b0;
            r_m_memread  <= 1'b0;
            r_m_memwrite <= 1'b0;
            r_m_byte     <= 1'b0;
            r_m_rd       <= 5'd0;
        end else if (!w_stall_em) begin
            r_m_regwrite <= r_e_regwrite;
            r_m_memtoreg <= r_e_memtoreg;
            r_m_memread  <= r_e_memread;
            r_m_memwrite <= r_e_memwrite;
            r_m_byte     <= r_e_byte;
            r_m_rd       <= r_e_rd;
        end
    end

    // W stage: bubble while M waits so a write-back is never repeated
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || w_stall_em) begin
            r_w_regwrite <= 1'b0;
            r_w_memtoreg <= 1'b0;
            r_w_byte     <= 1'b0;
            r_w_rd       <= 5'd0;
        end else begin
            r_w_regwrite <= r_m_regwrite;
            r_w_memtoreg <= r_m_memtoreg;
            r_w_byte     <= r_m_byte;
            r_w_rd       <= r_m_rd;
        end
    end

    assign bus.LoadD       = w_d_load;
    assign bus.ByteD       = w_d_byte;
    assign bus.IllegalD    = !w_legal;
    assign bus.AluControlE = r_e_alu;
    assign bus.ALUSrcE     = r_e_alusrc;
    assign bus.MemWriteM   = r_m_memwrite;
    assign bus.MemReadM    = r_m_memread;
    assign bus.RegWriteW   = r_w_regwrite;
    assign bus.MemtoRegW   = r_w_memtoreg;
    assign bus.ByteW       = r_w_byte;
    assign bus.StallF      = w_stall_fd;
    assign bus.StallD      = w_stall_fd;
    assign bus.StallE      = w_stall_em;
    assign bus.StallM      = w_stall_em;
    assign bus.FlushE      = w_flush_e;
endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Self-checking bench for pipe_ctrl: directed scenarios plus
//                random instruction streams against an instruction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    pipe_ctrl_if bus();

    pipe_ctrl dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] c_NOP   = 32'h0000_0000; // illegal -> clean bubble
    localparam logic [31:0] c_ADD3  = 32'h0020_81B3; // add  x3,x1,x2
    localparam logic [31:0] c_LW5   = 32'h0000_A283; // lw   x5,0(x1)
    localparam logic [31:0] c_ADD6  = 32'h0052_8333; // add  x6,x5,x5
    localparam logic [31:0] c_SB    = 32'h0020_80A3; // sb   x2,1(x1)
    localparam logic [31:0] c_ADDI0 = 32'h0050_8013; // addi x0,x1,5
    localparam logic [31:0] c_ADD7  = 32'h0000_03B3; // add  x7,x0,x0
    localparam logic [31:0] c_LH    = 32'h0000_9283; // lh   (unsupported)
    localparam logic [31:0] c_SLL   = 32'h0020_91B3; // sll  (unsupported)
    localparam logic [16:0] c_RESET_OUT = {3'b001, 3'b010, 11'b0};

    // One instruction as the model sees it
    typedef struct packed {
        logic       legal, load, byt, alusrc, memread, memwrite, memtoreg, regwrite;
        logic [2:0] alu;
        logic [4:0] rd, rs1, rs2;
        logic       uses_rs2;
    } rec_t;

    function automatic rec_t bubble();
        rec_t r;
        r     = '0;
        r.alu = 3'b010;
        return r;
    endfunction

    // Instruction meaning by mnemonic
    function automatic rec_t decode(input logic [31:0] ins);
        rec_t r;
        logic [6:0] op, f7;
        logic [2:0] f3;
        r  = bubble();
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        r.rd  = ins[11:7];
        r.rs1 = ins[19:15];
        r.rs2 = ins[24:20];
        r.uses_rs2 = (op == 7'b0110011) || (op == 7'b0100011);
        if (op == 7'b0110011 && f7 == 7'h00 && f3 == 3'b000) begin
            r.legal = 1; r.regwrite = 1; r.alu = 3'b010;                 // ADD
        end else if (op == 7'b0110011 && f7 == 7'h20 && f3 == 3'b000) begin
            r.legal = 1; r.regwrite = 1; r.alu = 3'b110;                 // SUB
        end else if (op == 7'b0110011 && f7 == 7'h00 && f3 == 3'b111) begin
            r.legal = 1; r.regwrite = 1; r.alu = 3'b000;                 // AND
        end else if (op == 7'b0110011 && f7 == 7'h00 && f3 == 3'b110) begin
            r.legal = 1; r.regwrite = 1; r.alu = 3'b001;                 // OR
        end else if (op == 7'b0010011 && f3 == 3'b000) begin
            r.legal = 1; r.load = 1; r.alusrc = 1; r.regwrite = 1;       // ADDI
        end else if (op == 7'b0000011 && (f3 == 3'b010 || f3 == 3'b000)) begin
            r.legal = 1; r.load = 1; r.alusrc = 1; r.memread = 1;        // LW/LB
            r.memtoreg = 1; r.regwrite = 1; r.byt = (f3 == 3'b000);
        end else if (op == 7'b0100011 && (f3 == 3'b010 || f3 == 3'b000)) begin
            r.legal = 1; r.alusrc = 1; r.memwrite = 1;                   // SW/SB
            r.byt = (f3 == 3'b000);
        end
        return r;
    endfunction

    function automatic logic hits(input rec_t older, input rec_t d);
        return older.regwrite && older.rd != 5'd0 &&
               (older.rd == d.rs1 || (d.uses_rs2 && older.rd == d.rs2));
    endfunction

    rec_t        m_e, m_m, m_w, m_d;
    logic        m_mw, m_raw;
    logic [16:0] expv, obs;

    always_comb begin
        m_d   = decode(bus.instrD);
        m_mw  = (m_m.memread || m_m.memwrite) && !bus.dmem_ready;
        m_raw = hits(m_e, m_d) || hits(m_m, m_d) || hits(m_w, m_d);
        expv  = {m_d.load, m_d.byt, !m_d.legal, m_e.alu, m_e.alusrc,
                 m_m.memwrite, m_m.memread, m_w.regwrite, m_w.memtoreg, m_w.byt,
                 m_mw || m_raw, m_mw || m_raw, m_mw, m_mw, m_raw && !m_mw};
    end

    assign obs = {bus.LoadD, bus.ByteD, bus.IllegalD, bus.AluControlE, bus.ALUSrcE,
                  bus.MemWriteM, bus.MemReadM, bus.RegWriteW, bus.MemtoRegW, bus.ByteW,
                  bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushE};

    // Model pipeline: instructions move one slot per cycle unless memory is waiting
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_e <= bubble();
            m_m <= bubble();
            m_w <= bubble();
        end else if (m_mw) begin
            m_w <= bubble();
        end else begin
            m_w <= m_m;
            m_m <= m_e;
            m_e <= (m_raw || !m_d.legal) ? bubble() : m_d;
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [2:0]  f3;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        imm = 12'($urandom);
        f3  = ($urandom_range(0, 1) != 0) ? 3'b010 : 3'b000;
        case ($urandom_range(0, 9))
            0:       return {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
            1:       return {7'h20, rs2, rs1, 3'b000, rd, 7'b0110011};
            2:       return {7'h00, rs2, rs1, 3'b111, rd, 7'b0110011};
            3:       return {7'h00, rs2, rs1, 3'b110, rd, 7'b0110011};
            4:       return {imm, rs1, 3'b000, rd, 7'b0010011};
            5, 9:    return {imm, rs1, f3, rd, 7'b0000011};
            6:       return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            7:       return $urandom;
            default: return {7'($urandom), rs2, rs1, 3'($urandom), rd, 7'b0110011};
        endcase
    endfunction

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_pipe();
        bus.instrD     = c_NOP;
        bus.dmem_ready = 1'b1;
        repeat (4) advance();
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.instrD     = c_NOP;
        bus.dmem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (obs !== c_RESET_OUT) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, c_RESET_OUT);
        end
        checks++;
        if (dut.r_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", dut.r_state);
        end
        rst_n = 1'b1;
        advance();
    endtask

    task automatic test_add();
        flush_pipe();
        bus.instrD = c_ADD3;
        #2;
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL add_decode: got %h expected %h", obs, expv);
        end
        advance();
        bus.instrD = c_NOP;
        for (int k = 1; k <= 5; k++) begin
            #2;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL add_model c%0d: got %h expected %h", k, obs, expv);
            end
            if (k == 1) begin
                checks++;
                if (bus.AluControlE !== 3'b010) begin
                    errors++;
                    $display("FAIL add_alu_e: got %b expected 010", bus.AluControlE);
                end
            end
            checks++;
            if (bus.RegWriteW !== (k == 3)) begin
                errors++;
                $display("FAIL add_regwrite_w c%0d: got %b expected %b", k, bus.RegWriteW, k == 3);
            end
            advance();
        end
    endtask

    task automatic test_load_use();
        int  stalls = 0;
        int  pulses = 0;
        bit  accepted = 0;
        flush_pipe();
        bus.instrD = c_LW5;
        #2;
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL lu_decode: got %h expected %h", obs, expv);
        end
        advance();
        for (int k = 1; k <= 9; k++) begin
            bus.instrD = accepted ? c_NOP : c_ADD6;
            #2;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL lu_model c%0d: got %h expected %h", k, obs, expv);
            end
            if (bus.StallD && bus.FlushE) stalls++;
            if (bus.RegWriteW) pulses++;
            if (!bus.StallD) accepted = 1;
            advance();
        end
        checks++;
        if (stalls != 3) begin
            errors++;
            $display("FAIL lu_stall_cycles: got %0d expected 3", stalls);
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL lu_regwrite_pulses: got %0d expected 2", pulses);
        end
    endtask

    task automatic test_mem_wait();
        flush_pipe();
        bus.instrD = c_SB;
        #2;
        checks++;
        if ({bus.ByteD, bus.LoadD, bus.IllegalD} !== 3'b100) begin
            errors++;
            $display("FAIL mw_decode: got %b expected 100", {bus.ByteD, bus.LoadD, bus.IllegalD});
        end
        advance();
        bus.instrD = c_NOP;
        for (int k = 1; k <= 7; k++) begin
            bus.dmem_ready = (k >= 2 && k <= 5) ? 1'b0 : 1'b1;
            #2;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL mw_model c%0d: got %h expected %h", k, obs, expv);
            end
            if (k >= 2 && k <= 6) begin
                checks++;
                if ({bus.MemWriteM, bus.StallM} !== {1'b1, k != 6}) begin
                    errors++;
                    $display("FAIL mw_wait c%0d: got %b expected %b", k,
                             {bus.MemWriteM, bus.StallM}, {1'b1, k != 6});
                end
            end
            if (k == 7) begin
                checks++;
                if (bus.MemWriteM !== 1'b0) begin
                    errors++;
                    $display("FAIL mw_release: got %b expected 0", bus.MemWriteM);
                end
            end
            advance();
        end
    endtask

    task automatic test_x0();
        logic [31:0] seq [5];
        seq = '{c_ADDI0, c_ADD7, c_NOP, c_NOP, c_NOP};
        flush_pipe();
        for (int k = 0; k < 5; k++) begin
            bus.instrD = seq[k];
            #2;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL x0_model c%0d: got %h expected %h", k, obs, expv);
            end
            checks++;
            if (bus.StallD !== 1'b0) begin
                errors++;
                $display("FAIL x0_no_stall c%0d: got %b expected 0", k, bus.StallD);
            end
            advance();
        end
    endtask

    task automatic test_illegal();
        logic [31:0] seq [7];
        seq = '{32'hFFFF_FFFF, c_LH, c_SLL, c_NOP, c_NOP, c_NOP, c_NOP};
        flush_pipe();
        for (int k = 0; k < 7; k++) begin
            bus.instrD = seq[k];
            #2;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL ill_model c%0d: got %h expected %h", k, obs, expv);
            end
            if (k <= 2) begin
                checks++;
                if (bus.IllegalD !== 1'b1) begin
                    errors++;
                    $display("FAIL ill_flag c%0d: got %b expected 1", k, bus.IllegalD);
                end
            end
            if (k == 1) begin
                checks++;
                if ({bus.ALUSrcE, bus.AluControlE} !== 4'b0010) begin
                    errors++;
                    $display("FAIL ill_bubble_e: got %b expected 0010", {bus.ALUSrcE, bus.AluControlE});
                end
            end
            if (k >= 3 && k <= 5) begin
                checks++;
                if ({bus.RegWriteW, bus.MemReadM} !== 2'b00) begin
                    errors++;
                    $display("FAIL ill_no_effect c%0d: got %b expected 00", k, {bus.RegWriteW, bus.MemReadM});
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_memwait();
        flush_pipe();
        bus.instrD = c_LW5;
        advance();
        bus.instrD = c_NOP;
        advance();
        bus.dmem_ready = 1'b0;
        #2;
        checks++;
        if (bus.StallM !== 1'b1 || obs !== expv) begin
            errors++;
            $display("FAIL rm_wait_entry: got %h expected %h", obs, expv);
        end
        advance();
        #2;
        checks++;
        if (bus.StallM !== 1'b1) begin
            errors++;
            $display("FAIL rm_in_wait: got %b expected 1", bus.StallM);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== c_RESET_OUT) begin
            errors++;
            $display("FAIL rm_async_reset: got %h expected %h", obs, c_RESET_OUT);
        end
        checks++;
        if (dut.r_state !== 2'd0) begin
            errors++;
            $display("FAIL rm_state_run: got %0d expected 0", dut.r_state);
        end
        advance();
        rst_n          = 1'b1;
        bus.dmem_ready = 1'b1;
        bus.instrD     = c_ADD3;
        #2;
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL rm_decode: got %h expected %h", obs, expv);
        end
        advance();
        bus.instrD = c_NOP;
        for (int k = 1; k <= 3; k++) begin
            #2;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL rm_model c%0d: got %h expected %h", k, obs, expv);
            end
            if (k == 3) begin
                checks++;
                if (bus.RegWriteW !== 1'b1) begin
                    errors++;
                    $display("FAIL rm_writeback: got %b expected 1", bus.RegWriteW);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        bit hold = 0;
        flush_pipe();
        for (int n = 0; n < 500; n++) begin
            if (!hold) bus.instrD = rand_instr();
            bus.dmem_ready = ($urandom_range(0, 3) != 0);
            #2;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL rand_model n%0d instr %h: got %h expected %h", n, bus.instrD, obs, expv);
            end
            hold = bus.StallD;
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_use();
        test_mem_wait();
        test_x0();
        test_illegal();
        test_reset_memwait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port reset, input, 1 bit: active-low asynchronous reset.
REQ-004 Port instrD, input, 32 bits: decode-stage instruction (rd=[11:7], rs1=[19:15], rs2=[24:20]).
REQ-005 Port dmem_ready, input, 1 bit: data memory has completed the current M-stage access.
REQ-006 Ports LoadD, ByteD, output, 1 bit each: decode-stage immediate select (I-format) and byte-store select.
REQ-007 Ports AluControlE (3 bits) and ALUSrcE (1 bit), output: execute-stage ALU operation and immediate select.
REQ-008 Ports MemWriteM and MemReadM, output, 1 bit each: memory-stage store and load strobes.
REQ-009 Ports RegWriteW, MemtoRegW and ByteW, output, 1 bit each: writeback-stage controls.
REQ-010 Ports StallF, StallD, StallE, StallM and FlushE, output, 1 bit each: pipeline-register hold and bubble controls.
REQ-011 Port IllegalD, output, 1 bit: instrD is not a supported encoding.

Function
REQ-012 The block SHALL decode the following instructions:
- ADD/SUB/AND/OR (opcode 0110011; SUB when funct7[5]=1): AluControl 010/110/000/001, RegWrite=1.
- ADDI (opcode 0010011, funct3 000): AluControl 010, ALUSrc=1, Load=1, RegWrite=1.
- LW/LB (opcode 0000011, funct3 010/000): AluControl 010, ALUSrc=1, Load=1, MemRead=1, MemtoReg=1, RegWrite=1, Byte = (funct3==000).
- SW/SB (opcode 0100011, funct3 010/000): AluControl 010, ALUSrc=1, Load=0, MemWrite=1, Byte = (funct3==000).
REQ-013 Any other encoding SHALL assert IllegalD combinationally and SHALL enter the E stage as a bubble (all controls 0).
REQ-014 Decoded controls SHALL be registered in order D→E→M→W, one stage per un-stalled cycle, so that each control reaches its suffixed stage exactly 1/2/3 cycles after decode.
REQ-015 Destination tracking: a RegWrite with rd=0 SHALL be treated as no write for hazard purposes.
REQ-016 RAW hazard: StallF=StallD=1 and FlushE=1 SHALL be asserted combinationally when a source register of instrD (rs1 always; rs2 for R-type and stores) that is nonzero equals the rd of a valid writing instruction in E, M or W.
REQ-017 The FSM SHALL have three states: RUN, HAZ and MEMWAIT.
- RUN→HAZ on a RAW hazard.
- HAZ→RUN when the hazard clears.
- Any state→MEMWAIT when (MemReadM|MemWriteM)=1 and dmem_ready=0.
- MEMWAIT→RUN on dmem_ready=1.
REQ-018 In MEMWAIT, StallF, StallD, StallE and StallM SHALL all be 1, FlushE SHALL be 0, and no stage control register SHALL change.
REQ-019 In MEMWAIT, the W stage SHALL receive a bubble so that RegWriteW is asserted only once for the completed instruction.
REQ-020 When a memory wait and a RAW hazard coincide, the memory wait SHALL take priority, and the hazard SHALL be re-evaluated on the cycle after release.
REQ-021 A bubble SHALL clear RegWrite, MemRead, MemWrite, MemtoReg, Byte and ALUSrc, and SHALL set AluControl to 010.
REQ-022 Stall outputs SHALL be combinational from state and current inputs; the block SHALL have no other combinational input-to-output path except decode-stage LoadD, ByteD and IllegalD.

Reset
REQ-023 While reset=0, all E/M/W control registers SHALL be 0 (AluControlE=010), the FSM SHALL be in RUN, and all stall and flush outputs SHALL be 0.
REQ-024 Reset asserted mid-stall or mid-MEMWAIT SHALL abandon the in-flight state immediately and asynchronously.
REQ-025 The first rising edge after reset deassertion SHALL decode instrD normally.

Verification
REQ-026 Scenario: ADD x3,x1,x2 with no hazards → AluControlE=010 at cycle+1 and RegWriteW=1 at cycle+3 for exactly one cycle.
REQ-027 Scenario: LW x5,0(x1) followed by ADD x6,x5,x5 → StallD=1 and FlushE=1 for 3 cycles, then the ADD proceeds with no duplicate RegWriteW.
REQ-028 Scenario: SB x2,1(x1) with dmem_ready held low for 4 cycles → MemWriteM=1 and StallM=1 for 4 cycles, release on the 5th cycle, and ByteD=1 at decode.
REQ-029 Scenario: ADDI x0,x1,5 followed by ADD x7,x0,x0 → no stall.
REQ-030 Scenario: instrD=0xFFFFFFFF → IllegalD=1 and a bubble at E (RegWriteE=0).
REQ-031 Scenario: reset pulled low during MEMWAIT → all outputs are at reset values within the same cycle, the FSM is in RUN, and the next instruction decodes normally.
